// File: rtl/niosII_system_switch_poller_pkg.sv
// Shared types and constants for the switch poller: master FSM states,
// the PIO data register offset and counter sizing helpers.
package niosII_system_switch_poller_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    localparam int unsigned PIO_DATA_OFFSET = 0;

    // Width of a counter holding 0..n-1 (never narrower than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Width of a saturating counter holding 0..n.
    function automatic int sat_width(input int n);
        return cnt_width(n + 1);
    endfunction

endpackage

// File: rtl/niosii_system_switch_poller_if.sv
// Avalon-MM read-only master port between the poller and the switch PIO.
// Handshake: avm_read stays high until a cycle with avm_waitrequest low, which
// accepts the read; avm_readdata is valid exactly one cycle after acceptance.
interface niosii_system_switch_poller_if;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address,
        output avm_read,
        input  avm_waitrequest,
        input  avm_readdata
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        output avm_waitrequest,
        output avm_readdata
    );
endinterface

// File: rtl/niosII_system_switch_debounce.sv
// Debounces one sampled bit: a new level is accepted after SAMPLES
// consecutive identical samples; a change pulse fires only once a level exists.
module niosII_system_switch_debounce
    import niosII_system_switch_poller_pkg::*;
#(
    parameter int SAMPLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_en_i,
    input  logic sample_i,
    output logic state_o,
    output logic valid_o,
    output logic changed_o
);
    localparam int CW = sat_width(SAMPLES);
    localparam logic [CW-1:0] SAT = CW'(SAMPLES);

    logic          cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          valid_q, valid_d;
    logic          changed_q, changed_d;

    always_comb begin
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        state_d   = state_q;
        valid_d   = valid_q;
        changed_d = 1'b0;
        if (sample_en_i) begin
            if (sample_i == cand_q) begin
                if (cnt_q != SAT) cnt_d = cnt_q + 1'b1;
            end else begin
                cand_d = sample_i;
                cnt_d  = CW'(1);
            end
            if ((cnt_d == SAT) && (!valid_q || (cand_d != state_q))) begin
                state_d   = cand_d;
                valid_d   = 1'b1;
                changed_d = valid_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cand_q    <= 1'b0;
            cnt_q     <= '0;
            state_q   <= 1'b0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
        end
    end

    assign state_o   = state_q;
    assign valid_o   = valid_q;
    assign changed_o = changed_q;

endmodule

// File: rtl/niosii_system_switch_poller.sv
// Autonomous Avalon-MM poller for the switch PIO: periodic tick, read FSM with
// waitrequest timeout, and a debounced switch level for engine control.
module niosii_system_switch_poller
    import niosII_system_switch_poller_pkg::*;
#(
    parameter int POLL_CYCLES      = 50000,
    parameter int DEBOUNCE_SAMPLES = 4,
    parameter int TIMEOUT_CYCLES   = 16,
    parameter int READ_ADDR        = PIO_DATA_OFFSET
) (
    input  logic   clk,
    input  logic   reset_n,
    input  logic   enable_i,
    niosii_system_switch_poller_if.master avm,
    output logic   switch_state_o,
    output logic   switch_valid_o,
    output logic   switch_changed_o,
    output logic   bus_timeout_o,
    output logic   poll_overrun_o,
    output state_t state_o
);
    localparam int TW = cnt_width(POLL_CYCLES);
    localparam int SW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TICK_LAST  = TW'(POLL_CYCLES - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [SW-1:0] stall_q, stall_d;
    logic          pending_q, pending_d;
    logic          timeout_q, timeout_d;
    logic          overrun_q, overrun_d;
    logic          tick;
    logic          start;

    always_comb begin
        state_d   = state_q;
        stall_d   = stall_q;
        pending_d = pending_q;
        timeout_d = 1'b0;
        overrun_d = 1'b0;
        start     = 1'b0;
        tick      = (tick_q == TICK_LAST);
        tick_d    = tick ? '0 : tick_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (pending_q && enable_i) begin
                    state_d = REQ;
                    stall_d = '0;
                    start   = 1'b1;
                end
            end
            REQ: begin
                // Acceptance is checked first so it wins over a same-cycle timeout.
                if (!avm.avm_waitrequest) begin
                    state_d = CAPTURE;
                end else if (stall_q == STALL_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (start) pending_d = 1'b0;
        // A tick only counts as lost if the previous one is still waiting.
        if (tick) begin
            pending_d = 1'b1;
            overrun_d = pending_q && !start;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            stall_q   <= '0;
            pending_q <= 1'b0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            stall_q   <= stall_d;
            pending_q <= pending_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
        end
    end

    assign avm.avm_address = 2'(READ_ADDR);
    assign avm.avm_read    = (state_q == REQ);

    logic unused_rdata;
    assign unused_rdata = ^avm.avm_readdata[31:1];

    niosII_system_switch_debounce #(
        .SAMPLES (DEBOUNCE_SAMPLES)
    ) u_debounce (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_en_i (state_q == CAPTURE),
        .sample_i    (avm.avm_readdata[0]),
        .state_o     (switch_state_o),
        .valid_o     (switch_valid_o),
        .changed_o   (switch_changed_o)
    );

    assign bus_timeout_o  = timeout_q;
    assign poll_overrun_o = overrun_q;
    assign state_o        = state_q;

endmodule

// File: tb/tb_niosii_system_switch_poller.sv
// Directed bench for the switch poller: cadence, debounce, stalls, timeout,
// overrun (second instance with a short poll period) and mid-read reset.
module tb_niosii_system_switch_poller;
    import niosII_system_switch_poller_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset_n, reset2_n, enable, enable2;

    logic   sw_state, sw_valid, sw_chg, b_to, p_ovr;
    logic   sw_state2, sw_valid2, sw_chg2, b_to2, p_ovr2;
    state_t st, st2;

    niosii_system_switch_poller_if bus ();
    niosii_system_switch_poller_if bus2 ();

    niosii_system_switch_poller #(
        .POLL_CYCLES(8), .DEBOUNCE_SAMPLES(3), .TIMEOUT_CYCLES(4), .READ_ADDR(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable_i(enable), .avm(bus.master),
        .switch_state_o(sw_state), .switch_valid_o(sw_valid), .switch_changed_o(sw_chg),
        .bus_timeout_o(b_to), .poll_overrun_o(p_ovr), .state_o(st)
    );

    niosii_system_switch_poller #(
        .POLL_CYCLES(4), .DEBOUNCE_SAMPLES(3), .TIMEOUT_CYCLES(4), .READ_ADDR(0)
    ) dut2 (
        .clk(clk), .reset_n(reset2_n), .enable_i(enable2), .avm(bus2.master),
        .switch_state_o(sw_state2), .switch_valid_o(sw_valid2), .switch_changed_o(sw_chg2),
        .bus_timeout_o(b_to2), .poll_overrun_o(p_ovr2), .state_o(st2)
    );

    // scoreboard counters
    int errors = 0;
    int checks = 0;
    int chg_cnt = 0, to_cnt = 0, ovr2_cnt = 0, rise2_cnt = 0, to2_cnt = 0;
    logic rd2_prev = 1'b0;
    int g, l;

    always @(negedge clk) begin
        if (sw_chg)  chg_cnt++;
        if (b_to)    to_cnt++;
        if (p_ovr2)  ovr2_cnt++;
        if (b_to2)   to2_cnt++;
        if (bus2.avm_read && !rd2_prev) rise2_cnt++;
        rd2_prev = bus2.avm_read;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // driver: waits for the next read, stalls it `stalls` cycles, returns one
    // cycle after the read ends so the debounce result is visible
    task automatic poll(input int stalls, output int gap, output int rd_len);
        gap = 0;
        while (!bus.avm_read && gap < 64) begin
            @(negedge clk);
            gap++;
        end
        if (gap >= 64) begin
            checks++;
            errors++;
            $error("FAIL read_start_bound: observed=%0d expected<64", gap);
        end
        rd_len = 0;
        while (bus.avm_read && rd_len < 64) begin
            bus.avm_waitrequest = (rd_len < stalls);
            @(negedge clk);
            rd_len++;
        end
        bus.avm_waitrequest = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_bit(input logic b);
        bus.avm_readdata = {31'b0, b};
    endtask

    initial begin
        reset_n = 1'b0;
        reset2_n = 1'b0;
        enable = 1'b1;
        enable2 = 1'b1;
        bus.avm_waitrequest = 1'b0;
        bus.avm_readdata = 32'h1;
        bus2.avm_waitrequest = 1'b0;
        bus2.avm_readdata = 32'h1;
        repeat (3) @(negedge clk);

        check("rst_read",    bus.avm_read, 0);
        check("rst_addr",    bus.avm_address, 0);
        check("rst_state",   sw_state, 0);
        check("rst_valid",   sw_valid, 0);
        check("rst_changed", sw_chg, 0);
        check("rst_timeout", b_to, 0);
        check("rst_overrun", p_ovr, 0);
        check("rst_fsm",     st, IDLE);
        reset_n = 1'b1;

        // steady 1: reads every 8 cycles, level accepted on 3rd capture
        poll(0, g, l);
        check("first_gap", g, 9);
        check("min_read_len", l, 1);
        check("valid_after_1", sw_valid, 0);
        poll(0, g, l);
        check("gap_2", g, 6);
        check("valid_after_2", sw_valid, 0);
        poll(0, g, l);
        check("gap_3", g, 6);
        check("valid_after_3", sw_valid, 1);
        check("state_after_3", sw_state, 1);
        #1 check("no_initial_change", chg_cnt, 0);

        // toggles 0,1,0,0,0
        set_bit(1'b0); poll(0, g, l);
        set_bit(1'b1); poll(0, g, l);
        set_bit(1'b0); poll(0, g, l);
        poll(0, g, l);
        check("state_two_zeros", sw_state, 1);
        poll(0, g, l);
        check("state_three_zeros", sw_state, 0);
        #1 check("one_change_pulse", chg_cnt, 1);

        // two stall cycles then accept
        poll(2, g, l);
        check("stall2_read_len", l, 3);
        #1 check("stall2_no_timeout", to_cnt, 0);

        // stuck waitrequest: three aborted reads with bit 1 must not sample
        set_bit(1'b1);
        poll(99, g, l);
        check("timeout_read_len", l, 4);
        poll(99, g, l);
        poll(99, g, l);
        #1 check("timeout_pulses", to_cnt, 3);
        check("timeout_no_sample", sw_state, 0);

        // retry on the next tick, then three 1s flip the level back
        poll(0, g, l);
        check("retry_gap", g, 3);
        check("retry_len", l, 1);
        poll(0, g, l);
        poll(0, g, l);
        check("state_back_to_1", sw_state, 1);
        #1 check("two_change_pulses", chg_cnt, 2);

        // reset while in REQ
        g = 0;
        while (!bus.avm_read && g < 64) begin
            @(negedge clk);
            g++;
        end
        check("reached_req", bus.avm_read, 1);
        #2 reset_n = 1'b0;
        #1;
        check("reset_drops_read", bus.avm_read, 0);
        check("reset_state", sw_state, 0);
        check("reset_valid", sw_valid, 0);
        check("reset_fsm", st, IDLE);
        @(negedge clk);
        reset_n = 1'b1;
        poll(0, g, l);
        check("post_reset_gap", g, 9);
        check("post_reset_valid", sw_valid, 0);

        // overrun: 4-cycle ticks, every read stalled 3 cycles
        @(negedge clk);
        reset2_n = 1'b1;
        begin
            int k2;
            k2 = 0;
            repeat (60) begin
                bus2.avm_waitrequest = bus2.avm_read && (k2 < 3);
                k2 = bus2.avm_read ? k2 + 1 : 0;
                @(negedge clk);
            end
        end
        bus2.avm_waitrequest = 1'b0;
        #1;
        check("overrun_pulses", ovr2_cnt, 4);
        check("overrun_reads", rise2_cnt, 10);
        check("overrun_no_timeout", to2_cnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/niosii_system_switch_poller.md
# niosII_system_switch_poller

Avalon-MM master that autonomously polls the single-bit switch PIO slave (data register at word address 0, registered readdata, one-cycle read latency), debounces the sampled bit and presents a stable switch level plus a one-cycle change pulse to engine-control logic. It sits beside the Nios II data master on the system interconnect. Switch handling therefore needs no CPU reads.

## Interface
- POLL_CYCLES, 50000: clk cycles between poll ticks (1 ms at 50 MHz); legal range 4..2^20.
- DEBOUNCE_SAMPLES, 4: consecutive identical samples needed to accept a new level; legal range 1..15.
- TIMEOUT_CYCLES, 16: maximum cycles a read may be stalled by waitrequest before abort; legal range 1..255.
- READ_ADDR, 0: word address driven on avm_address.

- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low (the reset for this block is reset_n, asynchronous, active-low; the clock is clk).
- enable  in  1  level; 1 permits new poll reads.
- avm_address  out  2  read address; constant READ_ADDR.
- avm_read  out  1  read request.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  32  slave data; only bit 0 is used.
- switch_state  out  1  debounced switch level.
- switch_valid  out  1  1 once a first level has been accepted.
- switch_changed  out  1  one-cycle pulse when switch_state changes after valid.
- bus_timeout  out  1  one-cycle pulse on aborted read.
- poll_overrun  out  1  one-cycle pulse when a tick is lost.

## Operation
- Tick counter: free-running; counts 0..POLL_CYCLES-1, wraps, and emits a tick on wrap. It runs regardless of enable.
- pending flag: set by a tick and cleared on entering REQ. A tick arriving while pending is already 1 pulses poll_overrun; pending stays 1.
- FSM states:
  - IDLE: when pending=1 and enable=1, go to REQ.
  - REQ: avm_read=1. On a cycle with avm_waitrequest=0, the read is accepted; go to CAPTURE. If the stall count reaches TIMEOUT_CYCLES, pulse bus_timeout, drop avm_read, go to IDLE and take no sample.
  - CAPTURE: avm_read=0. Sample avm_readdata[0] in this cycle; go to IDLE.
- Debounce (one evaluation per CAPTURE):
  - If sample == candidate, cnt = min(cnt+1, DEBOUNCE_SAMPLES).
  - Otherwise candidate = sample and cnt = 1.
  - When cnt reaches DEBOUNCE_SAMPLES and (switch_valid=0 or candidate != switch_state), load switch_state = candidate.
  - On that load, set switch_valid=1. Pulse switch_changed only if switch_valid was already 1.
- enable deasserted mid-read: the in-flight read completes normally. Debounce state and pending are retained.
- Reset values: avm_read 0, avm_address READ_ADDR, switch_state 0, switch_valid 0, switch_changed 0, bus_timeout 0, poll_overrun 0. FSM IDLE, tick counter 0, pending 0, cnt 0, candidate 0.
- Reset asserted mid-read drops avm_read asynchronously.

## Timing
- Tick to avm_read: the tick sets pending at edge N; REQ and avm_read=1 appear from edge N+1.
- Minimum read: 1 cycle REQ plus 1 cycle CAPTURE.
- Sample to output: a CAPTURE at cycle C updates switch_state, switch_valid and switch_changed at edge C+1.
- Timeout: with waitrequest held at 1, avm_read is high for exactly TIMEOUT_CYCLES cycles. bus_timeout pulses in the cycle after the last stalled cycle.
- Accept and timeout in the same cycle: accept wins.
- Tick and CAPTURE in the same cycle: pending is set; no overrun.

## Structure
- Package niosII_system_switch_poller_pkg holds:
  - state enum: IDLE, REQ, CAPTURE;
  - the PIO data register offset constant (0);
  - counter width functions (clog2 of POLL_CYCLES, TIMEOUT_CYCLES, DEBOUNCE_SAMPLES).
- Sub-module niosII_system_switch_debounce holds candidate/cnt/state/valid and takes sample plus sample_en. The master FSM and tick counter stay in the top module.

## Test plan
- Defaults overridden to POLL_CYCLES=8, DEBOUNCE_SAMPLES=3, TIMEOUT_CYCLES=4; waitrequest=0 and slave bit held at 1.
  -> Reads every 8 cycles; switch_valid=1 and switch_state=1 after the 3rd CAPTURE; no switch_changed pulse.
- Stable 1, then slave bit toggles 0,1,0,0,0 on successive polls.
  -> switch_state goes to 0 only after the 3rd consecutive 0 sample; exactly one switch_changed pulse.
- waitrequest=1 for 2 cycles, then 0.
  -> avm_read high for 3 cycles; sample taken; no bus_timeout.
- waitrequest stuck at 1.
  -> avm_read high exactly 4 cycles, one bus_timeout pulse, no debounce update; the next tick retries.
- POLL_CYCLES=4, waitrequest=1 for 3 cycles each read, enable=1.
  -> poll_overrun pulses on the lost tick; the FSM never hangs.
- reset_n pulsed low while in REQ.
  -> avm_read drops immediately; all outputs at reset values; polling resumes after the first tick.
